// File: rtl/prime_gen.sv
// prime_gen: streams every prime p with 2 <= p <= limit in ascending order
// over a valid/ready handshake. Primality is found by trial division, one
// divisor per cycle. The divisor runs from 2 upward until div*div > cand.
// For candidates up to 31 the divisor therefore never passes 6, and a
// 3-bit divisor is enough.

// Protocol checker bound inside prime_gen; purely observational.
module prime_gen_chk (
    input logic       clk,
    input logic       rst,
    input logic       out_valid,
    input logic       out_ready,
    input logic [4:0] prime,
    input logic       busy,
    input logic       done
);

    // An offered prime stays offered and unchanged until it is taken.
    property p_hold_until_taken;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=> (out_valid && $stable(prime));
    endproperty
    a_hold_until_taken: assert property (p_hold_until_taken);

    // done is a single-cycle pulse.
    property p_done_pulse;
        @(posedge clk) disable iff (rst)
            done |=> !done;
    endproperty
    a_done_pulse: assert property (p_done_pulse);

    // The end-of-run cycle is never a busy cycle.
    property p_done_not_busy;
        @(posedge clk) disable iff (rst)
            !(done && busy);
    endproperty
    a_done_not_busy: assert property (p_done_not_busy);

    // A prime is only offered while the run is in progress.
    property p_valid_means_busy;
        @(posedge clk) disable iff (rst)
            out_valid |-> busy;
    endproperty
    a_valid_means_busy: assert property (p_valid_means_busy);

endmodule

module prime_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] limit,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [4:0] prime,
    output logic [3:0] count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TEST   = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Remainder of candidate by divisor. A zero divisor only occurs
    // outside TEST, where the result is unused; it returns the candidate.
    function automatic logic [4:0] rem_of(input logic [4:0] c, input logic [2:0] d);
        logic [4:0] r;
        if (d == 3'd0) begin
            r = c;
        end else begin
            r = c % {2'b00, d};
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [4:0] cand_q, cand_d;
    logic [2:0] div_q, div_d;
    logic [4:0] limit_q, limit_d;
    logic [4:0] prime_q, prime_d;
    logic [3:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Divisor square at 10 bits so 6*6 compares against cand without truncation.
    logic [9:0] div_sq_s;
    logic [4:0] rem_s;
    logic       advance_s;

    // Square of the divisor and remainder for the current candidate.
    always_comb begin
        div_sq_s = {7'd0, div_q} * {7'd0, div_q};
        rem_s    = rem_of(cand_q, div_q);
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        div_d     = div_q;
        limit_d   = limit_q;
        prime_d   = prime_q;
        count_d   = count_q;
        advance_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = 4'd0;
                    if (limit >= 5'd2) begin
                        limit_d = limit;
                        cand_d  = 5'd2;
                        div_d   = 3'd2;
                        state_d = TEST;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            TEST: begin
                if (div_sq_s > {5'd0, cand_q}) begin
                    prime_d = cand_q;
                    state_d = EMIT;
                end else if (rem_s == 5'd0) begin
                    advance_s = 1'b1;
                end else begin
                    div_d = div_q + 3'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    count_d   = count_q + 4'd1;
                    advance_s = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Move to the next candidate, or close the run at the latched bound.
        // Stopping at cand == limit_q keeps cand from ever wrapping past 31.
        if (advance_s) begin
            if (cand_q == limit_q) begin
                state_d = FINISH;
            end else begin
                cand_d  = cand_q + 5'd1;
                div_d   = 3'd2;
                state_d = TEST;
            end
        end else begin
            cand_d = cand_d;
        end

        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d == TEST) || (state_d == EMIT);
        done_d      = (state_d == FINISH);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 5'd0;
            div_q       <= 3'd0;
            limit_q     <= 5'd0;
            prime_q     <= 5'd0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            div_q       <= div_d;
            limit_q     <= limit_d;
            prime_q     <= prime_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign prime     = prime_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

    prime_gen_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid_q),
        .out_ready (out_ready),
        .prime     (prime_q),
        .busy      (busy_q),
        .done      (done_q)
    );

endmodule

// File: tb/tb_prime_gen.sv
// Scoreboard bench for prime_gen: expected primes are queued when a run is
// started and popped as each handshake is observed.
module tb_prime_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] limit;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] prime;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int n_checks;
    int n_err;
    int hs_cnt;
    int done_cnt;
    int sb[$];

    prime_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .limit     (limit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .prime     (prime),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        bit r;
        r = (n >= 2);
        for (int d = 2; d < n; d++) begin
            if ((n % d) == 0) r = 1'b0;
        end
        return r;
    endfunction

    // Handshake monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() > 0) e = sb.pop_front();
                else e = -1;
                chk("prime", int'(prime), e);
                hs_cnt = hs_cnt + 1;
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic run(input int lim, input int stall_p, input int stall_n,
                       input int repulse, input int rst_after, input int exp_count);
        int  stall_left;
        int  cyc;
        int  last_p;
        bit  fin;
        stall_left = stall_n;
        cyc        = 0;
        fin        = 1'b0;
        last_p     = -1;
        sb.delete();
        hs_cnt   = 0;
        done_cnt = 0;
        for (int p = 2; p <= lim; p++) begin
            if (is_prime(p)) begin
                sb.push_back(p);
                last_p = p;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        limit = 5'(lim);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), int'(lim >= 2));
        chk("done_after_start", int'(done), int'(lim < 2));
        while (!fin) begin
            if (cyc >= 400) begin
                chk("timeout", 0, 1);
                fin = 1'b1;
            end else if (rst_after > 0 && hs_cnt == rst_after) begin
                rst = 1'b1;
                #1;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_prime", int'(prime), 0);
                chk("rst_count", int'(count), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                sb.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                fin = 1'b1;
            end else if (done_cnt > 0) begin
                fin = 1'b1;
            end else begin
                cyc = cyc + 1;
                start = (repulse > 0 && cyc == 2);
                if (repulse > 0 && cyc >= 2) limit = 5'(repulse);
                if (out_valid && int'(prime) == stall_p && stall_left > 0) begin
                    out_ready  = 1'b0;
                    stall_left = stall_left - 1;
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_prime", int'(prime), stall_p);
                end else begin
                    out_ready = 1'b1;
                end
                @(posedge clk); #1;
                if (cyc == 1) chk("first_valid_latency", int'(out_valid), int'(lim >= 2));
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("count", int'(count), exp_count);
        chk("sb_empty", sb.size(), 0);
        chk("done_pulses", done_cnt, (rst_after > 0) ? 0 : 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
        if (rst_after == 0 && last_p > 0) chk("prime_hold", int'(prime), last_p);
        chk("stall_consumed", stall_left, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        hs_cnt    = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        limit     = 5'd0;
        out_ready = 1'b0;
        #3;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_prime", int'(prime), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run(31, 0, 0, 0, 0, 11);
        run(1, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);
        run(20, 5, 10, 0, 0, 8);
        run(31, 0, 0, 0, 7, 0);
        run(10, 0, 0, 0, 0, 4);
        run(13, 0, 0, 5, 0, 6);
        run(2, 0, 0, 0, 0, 1);
        run(9, 0, 0, 0, 0, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
